// File: rtl/boot_load_ctrl_pkg.sv
// Shared definitions for the boot image loader.
//   state_e        : 3-bit FSM state encoding
//   WORD_W         : memory / loader word width in bits
//   BYTES_PER_WORD : byte stride between consecutive words
//   word_addr()    : byte address of word <idx> relative to <base>
package boot_load_ctrl_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5
  } state_e;

  // 32-bit modulo arithmetic: an address walking past 32'hFFFF_FFFC simply wraps.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [WORD_W-1:0] idx);
    return base + idx * WORD_W'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/boot_timeout_cnt.sv
// Clearable saturating cycle counter with a terminal flag.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset (counter -> 0)
//   clr_i : synchronous clear, wins over counting
//   en_i  : count one per cycle while high, saturating at LIMIT
//   hit_o : high in the cycle whose edge would bring the count to LIMIT,
//           i.e. LIMIT enabled cycles after the last clear (LIMIT >= 1)
module boot_timeout_cnt #(
  parameter int unsigned LIMIT = 2**24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned      CNT_W    = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag one cycle early so the owner's state register and the counter
  // both reach their terminal values on the same edge.
  assign hit_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot image loader: copies a word stream from the SD file loader into memory
// starting at BASE_ADDR, then hands the shared memory port to the CPU.
//   clk27mhz, rst                       : clock / synchronous active-high reset
//   start                               : one-cycle pulse, begins the load (IDLE only)
//   ld_data, ld_valid, ld_ready         : loader word stream (valid/ready)
//   mem_idle, mem_ack                   : memory controller status / request accepted
//   mem_req, mem_we, mem_addr, mem_wdata: shared memory request port
//   cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_gnt : CPU requester, served only after the load
//   busy, done, err, word_cnt           : status and count of committed words
`ifndef BIN_SIZE
`define BIN_SIZE 16
`endif

module boot_load_ctrl
  import boot_load_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned BIN_BYTES   = `BIN_SIZE,
  parameter int unsigned TIMEOUT_CYC = 2**24
) (
  input  logic              clk27mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              mem_idle,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] word_cnt
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] cur_addr;
  logic [34:0]       bytes_after;
  logic              last_word;
  logic              to_en, to_clr, to_hit;

  assign cur_addr = word_addr(BASE_ADDR, word_cnt_q);

  // Bytes covered once the word in flight commits; widened so a huge count
  // cannot wrap and fake an early finish.
  assign bytes_after = (35'(word_cnt_q) + 35'd1) * 35'(BYTES_PER_WORD);
  assign last_word   = bytes_after >= 35'(BIN_BYTES);

  assign to_en  = (state_q == ST_WAIT_WORD) || (state_q == ST_WAIT_ACK);
  assign to_clr = (state_d != state_q);

  boot_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i (clk27mhz),
    .rst_i (rst),
    .clr_i (to_clr),
    .en_i  (to_en),
    .hit_o (to_hit)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    ld_ready   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_gnt    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (BIN_BYTES == 0) ? ST_DONE : ST_WAIT_WORD;
        end
      end

      // A handshake seen in the timeout cycle is honoured: the word was
      // already offered and accepted, so dropping it would lose data.
      ST_WAIT_WORD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          word_d  = ld_data;
          state_d = ST_ISSUE;
        end else if (to_hit) begin
          state_d = ST_ERR;
        end
      end

      // Address/data are presented early; only mem_req waits for an idle controller.
      ST_ISSUE: begin
        mem_we    = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = word_q;
        if (mem_idle) begin
          mem_req = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = word_q;
        if (mem_ack) begin
          word_cnt_d = word_cnt_q + 32'd1;
          state_d    = last_word ? ST_DONE : ST_WAIT_WORD;
        end else if (to_hit) begin
          state_d = ST_ERR;
        end
      end

      // Load finished: the CPU owns the memory port, combinationally.
      ST_DONE: begin
        mem_req   = cpu_req;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_gnt   = cpu_req & mem_idle;
      end

      default: begin
        // ST_ERR and unused encodings: everything quiet until reset.
      end
    endcase
  end

  // Control registers: reset to an idle, empty load.
  always_ff @(posedge clk27mhz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Word holding register: data only, always rewritten before it is issued.
  always_ff @(posedge clk27mhz) begin
    word_q <= word_d;
  end

  assign busy     = (state_q == ST_WAIT_WORD) || (state_q == ST_ISSUE) ||
                    (state_q == ST_WAIT_ACK);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign word_cnt = word_cnt_q;

endmodule

// File: doc/boot_load_ctrl.md
BOOT_LOAD_CTRL -- requirements
Module: boot_load_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: first memory byte address written by the load.
REQ-002 Parameter BIN_BYTES, default `BIN_SIZE: image length in bytes, rounded up to whole 32-bit words.
REQ-003 Parameter TIMEOUT_CYC, default 2**24: maximum cycles spent in WAIT_WORD or WAIT_ACK before an error.
REQ-004 clk27mhz  in  1: the single clock; all logic is on its rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 start  in  1: one-cycle pulse that begins the load.
REQ-007 ld_data  in  32, ld_valid  in  1, ld_ready  out  1: word stream from the SD file loader (little-endian packed).
REQ-008 mem_idle  in  1: memory controller is idle (controller state == 0).
REQ-009 mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32: shared memory request port.
REQ-010 mem_ack  in  1: controller accepted the request (controller left idle).
REQ-011 cpu_req  in  1, cpu_we  in  1, cpu_addr  in  32, cpu_wdata  in  32, cpu_gnt  out  1: CPU requester.
REQ-012 busy, done, err  out  1 each; word_cnt  out  32: count of words committed.

Function
REQ-013 States: IDLE, WAIT_WORD, ISSUE, WAIT_ACK, DONE, ERR.
REQ-014 IDLE: start moves to WAIT_WORD; if BIN_BYTES==0, start moves directly to DONE.
REQ-015 WAIT_WORD: ld_ready=1 only in this state; ld_valid&ld_ready captures ld_data into the word register and moves to ISSUE on the next cycle.
REQ-016 ISSUE: mem_req=0 while mem_idle=0; when mem_idle=1, assert mem_req=1, mem_we=1, mem_addr=BASE_ADDR+4*word_cnt, mem_wdata=word register, and move to WAIT_ACK.
REQ-017 WAIT_ACK: hold mem_req and all mem_* outputs stable until mem_ack=1; on the following cycle mem_req=0 and word_cnt increments.
REQ-018 After the ack, if 4*word_cnt >= BIN_BYTES (using the incremented count) go to DONE; otherwise go to WAIT_WORD.
REQ-019 Address arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFFC is not flagged.
REQ-020 Timeout counter clears on every state entry and counts in WAIT_WORD and WAIT_ACK only; reaching TIMEOUT_CYC forces ERR with mem_req=0.
REQ-021 busy=1 in WAIT_WORD, ISSUE and WAIT_ACK; done=1 only in DONE; err=1 only in ERR.
REQ-022 start is ignored outside IDLE; DONE and ERR are left only by rst.
REQ-023 Arbitration: in DONE the mem_* outputs mirror the cpu_* inputs combinationally, with mem_req=cpu_req and cpu_gnt=cpu_req&mem_idle.
REQ-024 Outside DONE, cpu_gnt=0; the loader has absolute priority, and a simultaneous cpu_req during a load is held off with no grant.
REQ-025 In IDLE and ERR, mem_req=0 and ld_ready=0.

Reset
REQ-026 rst=1 forces, on the next edge, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_ready=0, cpu_gnt=0, busy=0, done=0, err=0, word_cnt=0, timeout counter=0.
REQ-027 rst mid-transfer, including in WAIT_ACK with mem_req=1, drops mem_req on the next edge and discards the captured word.

Structure
REQ-028 A shared package holds the state encoding (3-bit enum), the word width (32) and the bytes-per-word constant (4).
REQ-029 One sub-module, boot_timeout_cnt, implements the clearable saturating timeout counter with terminal flag.

Verification
REQ-030 BIN_BYTES=16, BASE_ADDR=0x8000_0000, four words 0x11223344.. with mem_idle=1 and mem_ack after 2 cycles -> writes at 0x8000_0000/04/08/0C in order, word_cnt=4, done=1.
REQ-031 mem_idle=0 for 10 cycles while in ISSUE -> mem_req stays 0 until mem_idle=1, then asserts within 1 cycle.
REQ-032 cpu_req=1 throughout the load -> cpu_gnt=0 until done; in DONE, cpu_addr=0x100 with mem_idle=1 -> mem_addr=0x100 and cpu_gnt=1 in the same cycle.
REQ-033 TIMEOUT_CYC=100 with ld_valid held 0 after start -> err=1 exactly 100 cycles after WAIT_WORD entry, mem_req=0.
REQ-034 rst pulsed in WAIT_ACK of word 2 -> all outputs at reset values next cycle; a restart reloads from BASE_ADDR with word_cnt=0.
REQ-035 BIN_BYTES=6 -> exactly 2 words written, then done=1; BIN_BYTES=0 -> done=1 one cycle after start with no mem_req.
